// File: rtl/station_dest.sv
// station_dest -- destination tracker for the Follower digital core.
//
// Latches a destination station from GO commands, drives the motion enable
// `go`, compares each barcode ID against the destination and stops the
// follower on a match (arrived) or when no station has been seen for TIMEOUT
// cycles (lost). Both producers are acknowledged with same-cycle clear pulses.
//
// Optional feature: define ARRIVE_BUZZ_EN to generate an arrival tone on
// piezo/piezo_n. Without it piezo is tied 0 and piezo_n tied 1.
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   cmd, cmd_rdy   command word ([15:14] opcode, [5:0] dest ID) and valid
//   clr_cmd_rdy    same-cycle ack of cmd_rdy
//   ID, ID_vld     barcode station ID and valid
//   clr_ID_vld     same-cycle ack of ID_vld
//   go             motion enable
//   in_transit     high while heading to a destination
//   arrived, lost  one-cycle status pulses
//   piezo, piezo_n tone output and its complement
module station_dest #(
  parameter int TIMEOUT  = 50_000_000,
  parameter int BUZZ_DIV = 12_500,
  parameter int BUZZ_LEN = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  input  logic [7:0]  ID,
  input  logic        ID_vld,
  output logic        clr_ID_vld,
  output logic        go,
  output logic        in_transit,
  output logic        arrived,
  output logic        lost,
  output logic        piezo,
  output logic        piezo_n
);

  localparam int WW = $clog2(TIMEOUT);
  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  typedef enum logic {IDLE, TRANSIT} state_t;

  state_t        state;
  logic [5:0]    dest_id;
  logic [WW-1:0] wdog;

  logic [1:0] op;
  logic       match;
  logic       expire;
  logic       arrive_evt;

  assign op     = cmd[15:14];
  assign match  = (ID[7:6] == 2'b00) && (ID[5:0] == dest_id);
  assign expire = (wdog == WW'(TIMEOUT - 1));

  // Gated by rst_n so nothing is acknowledged while held in reset; a request
  // still pending at release is serviced afterwards.
  assign clr_cmd_rdy = cmd_rdy & rst_n;
  assign clr_ID_vld  = ID_vld & ~cmd_rdy & rst_n;

  assign arrive_evt = (state == TRANSIT) && !cmd_rdy && ID_vld && match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dest_id    <= 6'h00;
      wdog       <= '0;
      go         <= 1'b0;
      in_transit <= 1'b0;
      arrived    <= 1'b0;
      lost       <= 1'b0;
    end else begin
      arrived <= 1'b0;
      lost    <= 1'b0;
      case (state)
        IDLE: begin
          // IDs seen while idle are acked combinationally and discarded.
          if (cmd_rdy && op == OP_GO) begin
            dest_id    <= cmd[5:0];
            go         <= 1'b1;
            in_transit <= 1'b1;
            wdog       <= '0;
            state      <= TRANSIT;
          end
        end
        TRANSIT: begin
          if (cmd_rdy) begin
            if (op == OP_STOP) begin
              go         <= 1'b0;
              in_transit <= 1'b0;
              wdog       <= '0;
              state      <= IDLE;
            end else if (op == OP_GO) begin
              dest_id <= cmd[5:0];
              wdog    <= '0;
            end
            // illegal opcodes: acked, nothing else changes
          end else if (ID_vld) begin
            if (match) begin
              go         <= 1'b0;
              in_transit <= 1'b0;
              arrived    <= 1'b1;
              wdog       <= '0;
              state      <= IDLE;
            end else begin
              wdog <= '0;
            end
          end else if (expire) begin
            go         <= 1'b0;
            in_transit <= 1'b0;
            lost       <= 1'b1;
            wdog       <= '0;
            state      <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARRIVE_BUZZ_EN
  localparam int LW = $clog2(BUZZ_LEN + 1);
  localparam int DW = $clog2(BUZZ_DIV + 1);

  logic [LW-1:0] len_cnt;
  logic [DW-1:0] div_cnt;
  logic          tone_abort;

  assign tone_abort = cmd_rdy && (op == OP_GO || op == OP_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt <= '0;
      div_cnt <= '0;
      piezo   <= 1'b0;
    end else if (tone_abort) begin
      len_cnt <= '0;
      div_cnt <= '0;
      piezo   <= 1'b0;
    end else if (arrive_evt) begin
      // a repeat arrival restarts the full duration
      len_cnt <= LW'(BUZZ_LEN);
      div_cnt <= '0;
      piezo   <= 1'b0;
    end else if (len_cnt != '0) begin
      len_cnt <= len_cnt - 1'b1;
      if (len_cnt == LW'(1)) begin
        piezo <= 1'b0;
      end else if (div_cnt == DW'(BUZZ_DIV - 1)) begin
        div_cnt <= '0;
        piezo   <= ~piezo;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign piezo_n = ~piezo;
`else
  localparam int unused_buzz = BUZZ_DIV + BUZZ_LEN;
  logic unused_evt;
  assign unused_evt = arrive_evt;
  assign piezo      = 1'b0;
  assign piezo_n    = 1'b1;
`endif

  logic unused_cmd;
  assign unused_cmd = ^cmd[13:6];

endmodule

// File: tb/tb_station_dest.sv
module tb_station_dest;

  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = '0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic [7:0]  ID = '0;
  logic        ID_vld = 1'b0;
  logic        clr_ID_vld;
  logic        go, in_transit, arrived, lost, piezo, piezo_n;

  int n_chk = 0;
  int n_fail = 0;

  station_dest #(.TIMEOUT(TO), .BUZZ_DIV(4), .BUZZ_LEN(40)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .ID(ID), .ID_vld(ID_vld),
    .clr_ID_vld(clr_ID_vld), .go(go), .in_transit(in_transit),
    .arrived(arrived), .lost(lost), .piezo(piezo), .piezo_n(piezo_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic eg, input logic eit,
                            input logic ea, input logic el);
    check({tag, " go"}, int'(go), int'(eg));
    check({tag, " in_transit"}, int'(in_transit), int'(eit));
    check({tag, " arrived"}, int'(arrived), int'(ea));
    check({tag, " lost"}, int'(lost), int'(el));
  endtask

  typedef struct {
    logic        crdy;
    logic [15:0] c;
    logic        ivld;
    logic [7:0]  id;
    logic        ecc, eci, ego, eit, earr;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic crdy, logic [15:0] c, logic ivld, logic [7:0] id,
                              logic ecc, logic eci, logic ego, logic eit, logic earr);
    vec_t v;
    v.crdy = crdy; v.c = c; v.ivld = ivld; v.id = id;
    v.ecc = ecc; v.eci = eci; v.ego = ego; v.eit = eit; v.earr = earr;
    return v;
  endfunction

  // GO at a negedge, then watch for lost; optionally inject a non-matching
  // ID serviced at edge id_at (edge 0 = the edge where go rises).
  task automatic run_timeout(input string name, input int id_at, input int exp_edge);
    int got;
    got = -1;
    cmd = 16'h4015; cmd_rdy = 1'b1;
    @(negedge clk);
    cmd_rdy = 1'b0;
    check({name, " go rise"}, int'(go), 1);
    for (int n = 1; n <= 2200; n++) begin
      ID_vld = (n == id_at);
      ID = 8'h3F;
      @(negedge clk);
      ID_vld = 1'b0;
      if (lost) begin
        got = n;
        break;
      end
    end
    check({name, " lost edge"}, got, exp_edge);
    check({name, " go after lost"}, int'(go), 0);
    check({name, " arrived with lost"}, int'(arrived), 0);
    @(negedge clk);
    check({name, " lost width"}, int'(lost), 0);
  endtask

  initial begin
    vt[0]  = mk(0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 16'h4015, 0, 8'h00, 1, 0, 1, 1, 0); // GO 0x15
    vt[2]  = mk(0, 16'h0000, 1, 8'h07, 0, 1, 1, 1, 0); // passing station
    vt[3]  = mk(0, 16'h0000, 1, 8'h15, 0, 1, 0, 0, 1); // match
    vt[4]  = mk(0, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0); // arrived drops
    vt[5]  = mk(1, 16'h4015, 0, 8'h00, 1, 0, 1, 1, 0);
    vt[6]  = mk(1, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 0); // STOP
    vt[7]  = mk(0, 16'h0000, 1, 8'h15, 0, 1, 0, 0, 0); // idle ID discarded
    vt[8]  = mk(1, 16'h8015, 0, 8'h00, 1, 0, 0, 0, 0); // illegal in IDLE
    vt[9]  = mk(1, 16'h4015, 0, 8'h00, 1, 0, 1, 1, 0);
    vt[10] = mk(1, 16'h4020, 1, 8'h15, 1, 0, 1, 1, 0); // both: cmd wins
    vt[11] = mk(0, 16'h0000, 1, 8'h15, 0, 1, 1, 1, 0); // pending ID, no match
    vt[12] = mk(0, 16'h0000, 1, 8'h20, 0, 1, 0, 0, 1); // new dest matches
    vt[13] = mk(1, 16'h4015, 0, 8'h00, 1, 0, 1, 1, 0);
    vt[14] = mk(0, 16'h0000, 1, 8'h55, 0, 1, 1, 1, 0); // ID[7:6]!=0
    vt[15] = mk(1, 16'hC000, 0, 8'h00, 1, 0, 1, 1, 0); // illegal in TRANSIT
    vt[16] = mk(1, 16'h0000, 0, 8'h00, 1, 0, 0, 0, 0);

    // reset state
    repeat (2) @(negedge clk);
    check_regs("reset", 0, 0, 0, 0);
    check("reset piezo", int'(piezo), 0);
    check("reset piezo_n", int'(piezo_n), 1);
    check("reset clr_cmd_rdy", int'(clr_cmd_rdy), 0);
    check("reset clr_ID_vld", int'(clr_ID_vld), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cmd_rdy = vt[i].crdy; cmd = vt[i].c; ID_vld = vt[i].ivld; ID = vt[i].id;
      #1;
      check({t, " clr_cmd_rdy"}, int'(clr_cmd_rdy), int'(vt[i].ecc));
      check({t, " clr_ID_vld"}, int'(clr_ID_vld), int'(vt[i].eci));
      @(negedge clk);
      cmd_rdy = 1'b0; ID_vld = 1'b0;
      check_regs(t, vt[i].ego, vt[i].eit, vt[i].earr, 1'b0);
      check({t, " piezo_n"}, int'(piezo_n), 1);
    end

    // watchdog
    run_timeout("to_plain", 0, TO);
    run_timeout("to_id600", 600, 600 + TO);
    run_timeout("to_id_at_expiry", TO, 2 * TO); // service beats expiry

    // reset mid-transit with a pending GO that is serviced after release
    cmd = 16'h4015; cmd_rdy = 1'b1;
    @(negedge clk);
    check("mid go", int'(go), 1);
    cmd = 16'h4033;
    rst_n = 1'b0;
    #1;
    check("rst go", int'(go), 0);
    check("rst in_transit", int'(in_transit), 0);
    check("rst clr_cmd_rdy", int'(clr_cmd_rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel clr_cmd_rdy", int'(clr_cmd_rdy), 1);
    @(negedge clk);
    cmd_rdy = 1'b0;
    check_regs("rel", 1, 1, 0, 0);
    ID = 8'h33; ID_vld = 1'b1;
    @(negedge clk);
    ID_vld = 1'b0;
    check_regs("rel dest33", 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
